// File: rtl/tex_qspi_responder_pkg.sv
// Shared constants and types for the texture-ROM QSPI responder.
// Holds the accepted command, FSM state encoding and a nibble helper.
package tex_spi_pkg;

  localparam int          TEX_ADDR_W      = 24;
  localparam logic [7:0]  TEX_CMD_QREAD   = 8'h6B;
  localparam int          TEX_DUMMY_CLKS  = 8;
  localparam int          TEX_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  // Pick the high or low nibble of a byte.
  function automatic logic [3:0] nib_sel(
    input logic [7:0] b,
    input logic       hi
  );
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/tex_qspi_responder_if.sv
// Backing-memory read port of the texture responder.
// master: addr/req out, data in (valid the cycle after req).
interface tex_mem_if #(
  parameter int AW = 24
);

  logic [AW-1:0] addr;
  logic          req;
  logic [7:0]    data;

  modport master (
    output addr,
    output req,
    input  data
  );

  modport slave (
    input  addr,
    input  req,
    output data
  );

endinterface

// File: rtl/tex_qspi_responder_sync.sv
// Synchroniser for CSb/SCLK/IO0 plus SCLK rise/fall pulse generation.
// Ports: clk, rst, async csb/sclk/io0 in; csb_s, io0_s, sclk_rise/fall out.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic csb,
  input  logic sclk,
  input  logic io0,
  output logic csb_s,
  output logic io0_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [STAGES-1:0] csb_q;
  logic [STAGES-1:0] sclk_q;
  logic [STAGES-1:0] io0_q;
  logic              sclk_d;

  // CSb chain resets high so nothing is selected out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_q  <= '1;
      sclk_q <= '0;
      io0_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      csb_q  <= {csb_q[STAGES-2:0], csb};
      sclk_q <= {sclk_q[STAGES-2:0], sclk};
      io0_q  <= {io0_q[STAGES-2:0], io0};
      sclk_d <= sclk_q[STAGES-1];
    end
  end

  assign csb_s     = csb_q[STAGES-1];
  assign io0_s     = io0_q[STAGES-1];
  assign sclk_rise = sclk_q[STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[STAGES-1] & sclk_d;

endmodule

// File: rtl/tex_qspi_responder.sv
// QSPI quad-output fast-read (0x6B) responder streaming bytes from memory.
// Ports: i_clk/i_reset, SPI csb/sclk/io0 in, io/oe out, mem port, busy, cmd_err.
module tex_qspi_responder
  import tex_spi_pkg::*;
#(
  parameter int         ADDR_W      = TEX_ADDR_W,
  parameter logic [7:0] CMD_QREAD   = TEX_CMD_QREAD,
  parameter int         DUMMY_CLKS  = TEX_DUMMY_CLKS,
  parameter int         SYNC_STAGES = TEX_SYNC_STAGES
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_spi_csb,
  input  logic         i_spi_sclk,
  input  logic         i_spi_io0,
  output logic [3:0]   o_spi_io,
  output logic [3:0]   o_spi_oe,
  tex_mem_if.master    mem,
  output logic         o_busy,
  output logic         o_cmd_err
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS);

  logic csb_s;
  logic io0_s;
  logic rise;
  logic fall;

  spi_in_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (i_clk),
    .rst       (i_reset),
    .csb       (i_spi_csb),
    .sclk      (i_spi_sclk),
    .io0       (i_spi_io0),
    .csb_s     (csb_s),
    .io0_s     (io0_s),
    .sclk_rise (rise),
    .sclk_fall (fall)
  );

  spi_state_e        state, state_n;
  logic [4:0]        cnt, cnt_n;
  logic [7:0]        dcnt, dcnt_n;
  logic [23:0]       sh, sh_n;
  logic [3:0]        io_q, io_n;
  logic [3:0]        oe_q, oe_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              req_q, req_n;
  logic              err_q, err_n;
  logic              nib_lo, nib_lo_n;
  logic              req_d;
  logic [7:0]        pf_q;
  logic [23:0]       sh_in;
  logic [7:0]        byte_src;

  assign sh_in = {sh[22:0], io0_s};

  // Bypass the prefetch register on the capture cycle so a drive
  // edge landing right on it still sees the fresh byte.
  assign byte_src = req_d ? mem.data : pf_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      sh     <= '0;
      io_q   <= '0;
      oe_q   <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
      err_q  <= 1'b0;
      nib_lo <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dcnt   <= dcnt_n;
      sh     <= sh_n;
      io_q   <= io_n;
      oe_q   <= oe_n;
      addr_q <= addr_n;
      req_q  <= req_n;
      err_q  <= err_n;
      nib_lo <= nib_lo_n;
    end
  end

  // Prefetch: memory answers one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_d <= 1'b0;
      pf_q  <= '0;
    end else begin
      req_d <= req_q;
      if (req_d) begin
        pf_q <= mem.data;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dcnt_n   = dcnt;
    sh_n     = sh;
    io_n     = io_q;
    oe_n     = oe_q;
    addr_n   = addr_q;
    req_n    = 1'b0;
    err_n    = 1'b0;
    nib_lo_n = nib_lo;
    if (csb_s) begin
      // Deselect wins over any SCLK edge seen the same cycle.
      state_n  = ST_IDLE;
      cnt_n    = '0;
      dcnt_n   = '0;
      nib_lo_n = 1'b0;
      oe_n     = '0;
      io_n     = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_CMD;
          cnt_n   = '0;
        end
        ST_CMD: begin
          if (rise) begin
            sh_n  = sh_in;
            cnt_n = cnt + 5'd1;
            if (cnt == 5'd7) begin
              cnt_n = '0;
              if (sh_in[7:0] == CMD_QREAD) begin
                state_n = ST_ADDR;
              end else begin
                err_n   = 1'b1;
                state_n = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            sh_n  = sh_in;
            cnt_n = cnt + 5'd1;
            if (cnt == 5'd23) begin
              cnt_n   = '0;
              dcnt_n  = '0;
              addr_n  = sh_in[ADDR_W-1:0];
              req_n   = 1'b1;
              state_n = ST_DUMMY;
            end
          end
        end
        ST_DUMMY: begin
          if (fall && dcnt == DUMMY_LAST) begin
            oe_n     = 4'hF;
            io_n     = nib_sel(byte_src, 1'b1);
            nib_lo_n = 1'b1;
            state_n  = ST_DATA;
          end else if (rise && dcnt != DUMMY_LAST) begin
            dcnt_n = dcnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (fall) begin
            if (nib_lo) begin
              io_n     = nib_sel(byte_src, 1'b0);
              addr_n   = addr_q + ADDR_W'(1);
              req_n    = 1'b1;
              nib_lo_n = 1'b0;
            end else begin
              io_n     = nib_sel(byte_src, 1'b1);
              nib_lo_n = 1'b1;
            end
          end
        end
        ST_IGNORE: begin
          oe_n = '0;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign o_spi_io  = io_q;
  assign o_spi_oe  = oe_q;
  assign mem.addr  = addr_q;
  assign mem.req   = req_q;
  assign o_cmd_err = err_q;
  assign o_busy    = (state == ST_ADDR) ||
                     (state == ST_DUMMY) ||
                     (state == ST_DATA);

endmodule

// File: tb/tb_tex_qspi_responder.sv
// Scoreboard bench for tex_qspi_responder: SCLK = clk/4,
// memory data = addr[7:0] ^ 8'hA5.
module tb_tex_qspi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       csb;
  logic       sclk;
  logic       io0;
  logic [3:0] spi_io;
  logic [3:0] spi_oe;
  logic       busy;
  logic       cmd_err;
  logic       started = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cycles = 0;

  logic [3:0]  nq[$];
  logic [23:0] rq[$];

  tex_mem_if #(.AW(24)) mem ();

  tex_qspi_responder dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_spi_csb  (csb),
    .i_spi_sclk (sclk),
    .i_spi_io0  (io0),
    .o_spi_io   (spi_io),
    .o_spi_oe   (spi_oe),
    .mem        (mem.master),
    .o_busy     (busy),
    .o_cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem.req === 1'b1) begin
      mem.data <= mem.addr[7:0] ^ 8'hA5;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Nibble monitor: data driven on one SCLK fall is read on the next.
  always @(negedge sclk) begin
    if (started && spi_oe !== 4'h0) begin
      if (nq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL nib_unexpected: io %h oe %h", spi_io, spi_oe);
      end else begin
        logic [3:0] e;
        e = nq.pop_front();
        chk("oe_data", {28'd0, spi_oe}, 32'hF);
        chk("nibble", {28'd0, spi_io}, {28'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (started && cmd_err === 1'b1) begin
      err_cycles++;
    end
    if (started && mem.req === 1'b1) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_unexpected: addr %h", mem.addr);
      end else begin
        logic [23:0] e;
        e = rq.pop_front();
        chk("mem_addr", {8'd0, mem.addr}, {8'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic b);
    io0 = b;
    @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tick(v[i]);
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
    end
  endtask

  task automatic start_x;
    csb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic stop_x;
    repeat (4) @(negedge clk);
    csb = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic push_bytes(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] x;
      logic [7:0]  b;
      x = a + 24'(i);
      b = x[7:0] ^ 8'hA5;
      nq.push_back(b[7:4]);
      nq.push_back(b[3:0]);
    end
  endtask

  task automatic push_reqs(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      rq.push_back(a + 24'(i));
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    push_bytes(a, n);
    push_reqs(a, n + 1);
    start_x();
    send(32'h6B, 8);
    send({8'd0, a}, 24);
    chk("busy_addr", {31'd0, busy}, 32'd1);
    chk("oe_pre_dummy", {28'd0, spi_oe}, 32'd0);
    idle_ticks(8);
    chk("oe_pre_data", {28'd0, spi_oe}, 32'd0);
    idle_ticks(2 * n);
    stop_x();
    chk("nib_drain", nq.size(), 32'd0);
    chk("req_drain", rq.size(), 32'd0);
    chk("oe_after", {28'd0, spi_oe}, 32'd0);
  endtask

  initial begin
    int k;
    rst  = 1'b1;
    csb  = 1'b1;
    sclk = 1'b0;
    io0  = 1'b0;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("rst_io", {28'd0, spi_io}, 32'd0);
    chk("rst_oe", {28'd0, spi_oe}, 32'd0);
    chk("rst_addr", {8'd0, mem.addr}, 32'd0);
    chk("rst_req", {31'd0, mem.req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_read(24'h000010, 4);

    start_x();
    send(32'h03, 8);
    idle_ticks(16);
    chk("err_pulse", err_cycles, 32'd1);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_oe", {28'd0, spi_oe}, 32'd0);
    stop_x();

    do_read(24'hFFFFFE, 3);

    start_x();
    send(32'h6B, 8);
    send(32'h15, 5);
    stop_x();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    do_read(24'h000001, 1);

    push_bytes(24'h000020, 1);
    push_reqs(24'h000020, 2);
    start_x();
    send(32'h6B, 8);
    send(32'h000020, 24);
    idle_ticks(10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_oe", {28'd0, spi_oe}, 32'd0);
    chk("rstmid_io", {28'd0, spi_io}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    csb = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_nq", nq.size(), 32'd0);
    chk("rstmid_rq", rq.size(), 32'd0);
    do_read(24'h000040, 2);

    push_reqs(24'h000030, 1);
    start_x();
    send(32'h6B, 8);
    send(32'h000030, 24);
    idle_ticks(8);
    repeat (4) @(negedge clk);
    chk("mid_oe_on", {28'd0, spi_oe}, 32'hF);
    chk("mid_io_hi", {28'd0, spi_io}, 32'h9);
    csb = 1'b1;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (k == 0 && spi_oe == 4'h0) begin
        k = i;
      end
    end
    chk("mid_oe_off", {31'd0, (k >= 1 && k <= 3)}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_rq", rq.size(), 32'd0);

    chk("err_total", err_cycles, 32'd1);
    chk("nq_end", nq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
